// File: rtl/instr_sequencer.sv
// Multi-cycle sequencing FSM for the 16-bit CPU: shares the memory port between fetch and
// LOAD/STORE, and gates decoder write strobes to once per instruction. SEQ_PERF_CNT_EN adds instr_count.
module instr_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter logic [3:0]  LOAD_OP      = 4'b1101,
  parameter logic [3:0]  STORE_OP     = 4'b1110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op,
  input  logic        dec_reg_en,
  input  logic        dec_lr_en,
  input  logic        dec_out_en,
  input  logic        mem_ack,
  input  logic        halt_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_en,
  output logic        pc_en,
  output logic        reg_we,
  output logic        lr_we,
  output logic        out_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        timeout_err,
  output logic [15:0] instr_count
);

  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                in_access;
  logic                wait_expired;
  logic                is_mem_op;

  assign in_access    = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wait_expired = (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX)) && !mem_ack;
  assign is_mem_op    = (op == LOAD_OP) || (op == STORE_OP);

  // State register and memory wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic; the counter is zero in every state that can enter FETCH or MEM
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack)           state_d = S_DECODE;
        else if (wait_expired) state_d = S_ERR;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = is_mem_op ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ack)           state_d = S_WB;
        else if (wait_expired) state_d = S_ERR;
      end
      S_WB:     state_d = halt_req ? S_HALT : S_FETCH;
      S_HALT:   state_d = halt_req ? S_HALT : S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_BOOT;
    endcase
    if (in_access && !mem_ack && (state_d == state_q))
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
  end

  // Output decode; ir_en is the only output that follows mem_ack directly
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    reg_we      = 1'b0;
    lr_we       = 1'b0;
    out_we      = 1'b0;
    halted      = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_en   = mem_ack;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (op == STORE_OP);
      end
      S_WB: begin
        pc_en  = 1'b1;
        reg_we = dec_reg_en && !dec_out_en;
        out_we = dec_out_en;
        lr_we  = dec_lr_en;
      end
      S_HALT:  halted      = 1'b1;
      S_ERR:   timeout_err = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [COUNT_W-1:0] instr_count_q;

  // Retired-instruction counter, one per WB cycle, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  instr_count_q <= '0;
    else if (state_q == S_WB) instr_count_q <= instr_count_q + COUNT_W'(1);
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = COUNT_W'(0);
`endif

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle sequencing FSM for the 16-bit CPU datapath.
- Shares the single memory port between instruction fetch and LOAD/STORE data access.
- Gates the decoder's write strobes so each takes effect exactly once per instruction.
- Sits between the instruction decoder, the PC/LR/register-file/out-port enables and the memory interface.

Parameters:
- MEM_WAIT_MAX, 15: max cycles without mem_ack in FETCH or MEM before the error trap; legal range 1..255.
- LOAD_OP, 4'b1101: opcode routed through MEM as a read.
- STORE_OP, 4'b1110: opcode routed through MEM as a write.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  4  opcode field of the latched instruction register (ir[15:12]).
- dec_reg_en  in  1  register-file write request from decoder.
- dec_lr_en  in  1  link-register write request from decoder.
- dec_out_en  in  1  out-port write request (decoder wb_demux_sel AND reg_en).
- mem_ack  in  1  memory done; read data valid / write committed this cycle.
- halt_req  in  1  level request to stop after the current instruction.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (STORE), valid only with mem_req.
- addr_sel  out  1  memory address mux: 0 = PC, 1 = ea.
- ir_en  out  1  instruction-register load strobe.
- pc_en  out  1  PC update strobe; the PC takes the decoder's pc_sel source.
- reg_we  out  1  gated register-file write.
- lr_we  out  1  gated link-register write.
- out_we  out  1  gated out-port write.
- state  out  3  current FSM state code.
- halted  out  1  1 in HALT.
- timeout_err  out  1  sticky memory-timeout flag.
- instr_count  out  16  retired-instruction count; see Optional Feature.

Behaviour:
- All outputs are Moore decode of registered state and opcode; no combinational path from mem_ack to outputs other than ir_en.
- State codes: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- Reset (asynchronous, any time, including mid-access):
  - state=BOOT and wait counter=0.
  - timeout_err=0, instr_count=0.
  - Every strobe is 0 while rst=1 and in BOOT.
  - An interrupted access is abandoned; mem_req drops immediately.
- BOOT: goes to FETCH on the first clock edge after rst is released.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - ir_en = mem_ack, combinational in FETCH only.
  - On mem_ack go to DECODE. An ack in the first FETCH cycle is legal and counts.
- DECODE: one cycle, no strobes; go to EXEC.
- EXEC: one cycle, no strobes.
  - op==LOAD_OP or op==STORE_OP: go to MEM.
  - Otherwise: go to WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=(op==STORE_OP).
  - On mem_ack go to WB.
- WB: exactly one cycle.
  - pc_en=1.
  - reg_we=dec_reg_en and NOT dec_out_en.
  - out_we=dec_out_en.
  - lr_we=dec_lr_en.
  - Next state: HALT if halt_req=1, otherwise FETCH.
- HALT: no strobes, halted=1. Return to FETCH when halt_req=0.
- halt_req is sampled only in WB. An instruction in flight always completes.
- Wait counter:
  - 8-bit; cleared on entry to FETCH or MEM.
  - Increments each FETCH/MEM cycle without mem_ack.
  - If counter==MEM_WAIT_MAX and mem_ack=0: go to ERR.
  - Net effect: ack accepted up to MEM_WAIT_MAX+1 cycles after entry.
- ERR: all strobes 0, timeout_err=1. Exit only by reset.
- Throughput: non-memory instruction 4 cycles minimum; LOAD/STORE 5 cycles minimum; each memory wait cycle adds 1.
- mem_req stays asserted continuously until ack and deasserts the cycle after ack.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: instr_count increments by 1 on every WB cycle, 16-bit, wraps 0xFFFF->0x0000, cleared by reset.
- Undefined: instr_count is tied to 0 and no counter flops are built.

Test Plan:
- ADD (op=0001, dec_reg_en=1), ack same cycle as req -> state 1,2,3,5,1; reg_we and pc_en high only in the 4th cycle; ir_en one pulse.
- LOAD (op=1101), fetch ack after 2 wait cycles, data ack immediate -> mem_req high cycles 1-3 (addr_sel=0), then MEM with addr_sel=1, mem_we=0; reg_we in WB; 7 cycles total.
- STORE (op=1110) -> MEM cycle with mem_req=1, mem_we=1; reg_we=0, pc_en=1 in WB.
- OUT (dec_reg_en=1, dec_out_en=1) -> out_we=1, reg_we=0 in WB; BR.SUB (dec_lr_en=1) -> lr_we=1 in WB.
- halt_req raised in DECODE -> instruction completes, WB then HALT, halted=1; drop halt_req -> FETCH next cycle.
- MEM_WAIT_MAX=3, no ack in FETCH -> ERR after 4 cycles, timeout_err=1 sticky; rst pulse mid-MEM -> BOOT, mem_req=0 immediately; with SEQ_PERF_CNT_EN, 3 retired instructions -> instr_count=3.
